// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states, signedness
// control values and the iteration count.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

  localparam logic DIV_CONTROL  = 1'b1;
  localparam logic DIVU_CONTROL = 1'b0;
  localparam int   DIV_ITER     = 32;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step on the {rem, quo} working register:
// shift left, trial-subtract the divisor, keep the difference if non-negative.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] work_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] work_out
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = work_in << 1;
    // One guard bit above the 33-bit remainder so the sign of the trial is exact.
    trial   = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      work_out = {trial[WIDTH:0], shifted[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, 1'b1}};
    end else begin
      work_out = shifted;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: latches magnitudes and sign flags on start,
// runs WIDTH restoring steps, then presents {rem, quo} with a one-cycle div_ready.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               div_start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               div_ready
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [2*WIDTH:0]   step_out;
  logic [WIDTH-1:0]   abs1, abs2, quo_fin, rem_fin;

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .work_in  (work_q),
    .divisor  (divisor_q),
    .work_out (step_out)
  );

  always_comb begin
    abs1    = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    abs2    = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    quo_fin = q_neg_q ? -step_out[WIDTH-1:0] : step_out[WIDTH-1:0];
    rem_fin = r_neg_q ? -step_out[2*WIDTH-1:WIDTH] : step_out[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    div_ready = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (!annul && div_start) begin
          if (opdata2 == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d   = DIV_ON;
            count_d   = '0;
            work_d    = {{(WIDTH+1){1'b0}}, abs1};
            divisor_d = abs2;
            q_neg_d   = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            r_neg_d   = signed_div & opdata1[WIDTH-1];
          end
        end
      end
      DIV_BYZERO: begin
        if (annul) begin
          state_d = DIV_IDLE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
        end
      end
      DIV_ON: begin
        if (annul) begin
          state_d = DIV_IDLE;
        end else begin
          work_d  = step_out;
          count_d = count_q + CNT_W'(1);
          // The final step's output is sign-fixed straight into the result register.
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DIV_END;
            result_d = {rem_fin, quo_fin};
          end
        end
      end
      DIV_END: begin
        div_ready = !annul;
        state_d   = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by zero,
// annul, mid-operation reset and back-to-back operations.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        resetn;
  logic        div_start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        div_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_ready_cyc = 0;
  int pulses;

  div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_start  (div_start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .div_ready  (div_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request in cycle N, hold start until div_ready, drop it in END.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    @(negedge clk);
    chk({tag, "_ready_low_before"}, 64'(div_ready), 64'd0);
    div_start  = 1'b1;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = $urandom_range(0, 1);
      end
      if (div_ready) begin
        lat = k;
        last_ready_cyc = cyc;
        break;
      end
    end
    div_start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, result, exp_res);
  endtask

  initial begin
    int first_ready;
    resetn     = 1'b0;
    div_start  = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    annul      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(div_ready), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_state", 64'(dut.state_q), 64'(DIV_IDLE));
    resetn = 1'b1;

    run_div("divu_100_7", DIVU_CONTROL, 32'd100, 32'd7, 33, {32'h2, 32'hE});
    run_div("div_m7_2", DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div_7_m2", DIV_CONTROL, 32'd7, 32'hFFFF_FFFE, 33, {32'h1, 32'hFFFF_FFFD});
    run_div("div_m100_m7", DIV_CONTROL, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, {32'hFFFF_FFFE, 32'hE});
    run_div("div_ovf", DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});
    run_div("divu_ovf", DIVU_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'h0});
    run_div("div_by_zero", DIV_CONTROL, 32'd55, 32'd0, 2, 64'd0);
    run_div("divu_nonzero", DIVU_CONTROL, 32'd1000, 32'd10, 33, {32'h0, 32'h64});
    run_div("divu_by_zero", DIVU_CONTROL, 32'hFFFF_FFFF, 32'd0, 2, 64'd0);

    // Annul in cycle N+10.
    @(negedge clk);
    div_start  = 1'b1;
    signed_div = DIVU_CONTROL;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    pulses     = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (div_ready) pulses++;
    end
    annul     = 1'b1;
    div_start = 1'b0;
    @(negedge clk);
    chk("annul_state_idle", 64'(dut.state_q), 64'(DIV_IDLE));
    annul = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (div_ready) pulses++;
      @(negedge clk);
    end
    chk("annul_no_ready", 64'(pulses), 64'd0);
    run_div("after_annul_9_3", DIVU_CONTROL, 32'd9, 32'd3, 33, {32'h0, 32'h3});

    // Reset in cycle N+20.
    @(negedge clk);
    div_start  = 1'b1;
    signed_div = DIVU_CONTROL;
    opdata1    = 32'd1000;
    opdata2    = 32'd7;
    pulses     = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (div_ready) pulses++;
    end
    resetn    = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    chk("midreset_ready", 64'(div_ready), 64'd0);
    chk("midreset_result", result, 64'd0);
    chk("midreset_state", 64'(dut.state_q), 64'(DIV_IDLE));
    resetn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (div_ready) pulses++;
      @(negedge clk);
    end
    chk("midreset_no_ready", 64'(pulses), 64'd0);

    // Back-to-back: second start in the cycle right after END.
    run_div("b2b_first", DIVU_CONTROL, 32'd1000, 32'd10, 33, {32'h0, 32'h64});
    first_ready = last_ready_cyc;
    run_div("b2b_second", DIVU_CONTROL, 32'hFFFF_FFFF, 32'h10, 33, {32'hF, 32'h0FFF_FFFF});
    chk("b2b_spacing", 64'(last_ready_cyc - first_ready), 64'd34);
    @(negedge clk);
    chk("b2b_ready_single", 64'(div_ready), 64'd0);
    chk("b2b_result_hold", result, {32'hF, 32'h0FFF_FFFF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the EX stage, executing DIV and DIVU. It is the functional unit on the other side of the hazard unit's `div_start` / `div_ready` handshake. The hazard unit holds `div_start` high, and the IF–MEM stages stalled, until this block pulses `div_ready`. The block returns quotient and remainder for the HI/LO write path.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported; the parameter exists for bench scaling.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `resetn`, input, 1: synchronous, active-low reset.
- `div_start`, input, 1: from the hazard unit; high while a DIV/DIVU sits in EX and the result is not ready.
- `signed_div`, input, 1: 1 = DIV (signed), 0 = DIVU. Sampled with the operands.
- `opdata1`, input, 32: dividend, from the EX operand mux.
- `opdata2`, input, 32: divisor.
- `annul`, input, 1: cancel the operation in flight. Driven by exception flush.
- `result`, output, 64: {remainder[63:32] → HI, quotient[31:0] → LO}.
- `div_ready`, output, 1: one-cycle pulse; `result` is valid during it.

## Operation
- States:
  - IDLE: waiting for a request.
  - BYZERO: divisor was zero.
  - ON: iterating.
  - END: result valid.
- IDLE:
  - If `annul` is high: stay in IDLE. `annul` beats `div_start`.
  - Else if `div_start` is high and `opdata2 == 0`: go to BYZERO.
  - Else if `div_start` is high: latch the operands and `signed_div`, clear the count, go to ON.
- Latching (signed case): store `|opdata1|` and `|opdata2|`, plus sign flags `q_neg = op1[31]^op2[31]` and `r_neg = op1[31]`. Unsigned: raw operands, both flags 0.
- ON: one restoring step per cycle, for 32 steps.
  - Working register is 65 bits, {rem[32:0], quo[31:0]}.
  - Each step: shift the register left by 1, then compute the 33-bit trial value `rem - divisor`.
  - If the trial value is non-negative: `rem = trial` and `quo[0] = 1`.
  - After step 32: go to END.
- BYZERO: `result = 64'h0` (architecturally undefined, but fixed here for determinism). Go to END.
- END: `div_ready = 1`. `result` = quotient negated if `q_neg`, remainder negated if `r_neg`. Return to IDLE on the next edge.
- `result` is registered and holds its value until the next accepted start or reset.
- `annul` in ON, BYZERO or END: return to IDLE on the next edge; no `div_ready` pulse.
- Operand changes after acceptance are ignored; only latched values are used.
- Overflow case `0x80000000 / 0xFFFFFFFF` (signed) wraps to quotient `0x80000000`, remainder 0. No trap.

## Timing
- Reset values: state IDLE, `div_ready = 0`, `result = 64'h0`, count 0. Reset mid-operation aborts with no ready pulse.
- Normal divide: if `div_start` is first high in cycle N (IDLE), the ON steps occur in cycles N+1..N+32 and `div_ready` is high in cycle N+33 only.
- Divide by zero: `div_ready` is high in cycle N+2.
- `div_ready` is never high for two consecutive cycles.
- While in END, the hazard unit drops `div_start` combinationally. The pipeline advances and the EX/MEM register captures `result` in that same cycle.
- Back-to-back divides: a new `div_start` arriving in cycle N+34 (IDLE) is accepted. No dead cycle is required beyond END.
- `div_start` is ignored in ON, BYZERO and END.
- `annul` in cycle M: state is IDLE in cycle M+1.

## Structure
- Shared package / `defines.h`: state encodings (`DIV_IDLE`, `DIV_BYZERO`, `DIV_ON`, `DIV_END`), `DIV_CONTROL` / `DIVU_CONTROL`, and the iteration count constant (32).
- One sub-module is natural: `div_step`, a combinational shift-and-trial-subtract of the 65-bit working register, giving the next register value. It is unit-testable on its own.
- The top level holds the FSM, count, sign flags, operand latch and final sign fix-up.

## Test plan
- DIVU `100 / 7`: `result = {32'h2, 32'hE}`. `div_ready` high only in cycle N+33.
- DIV signed cases:
  - `-7 / 2` gives quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`.
  - `7 / -2` gives quotient `0xFFFFFFFD`, remainder `0x1`.
- `0x80000000 / 0xFFFFFFFF`:
  - DIV: quotient `0x80000000`, remainder 0.
  - DIVU: quotient 0, remainder `0x80000000`.
- Divide by zero (`opdata2 = 0`, either signedness): `result = 0`, `div_ready` high in cycle N+2.
- `annul` asserted in cycle N+10:
  - No `div_ready` pulse; state IDLE in cycle N+11.
  - A following DIVU `9 / 3` completes with `{0, 3}` 33 cycles after its start.
- `resetn` low in cycle N+20: `div_ready = 0`, `result = 0`.
- Back-to-back divides: two DIVU operations with `div_start` re-asserted immediately after END. Two ready pulses, 34 cycles apart, each with the correct result.
